// File: rtl/pin_mux_pkg.sv
// Shared types and pin-direction constants for the pin-level N:1 mux.
package pin_mux_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        BREAK = 1'b1
    } state_e;

    localparam logic PIN_DIR_IN  = 1'b1;
    localparam logic PIN_DIR_OUT = 1'b0;

endpackage

// File: rtl/pin_sync.sv
// WIDTH-bit multi-flop synchroniser with synchronous active-low reset.
module pin_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q <= '0;
        end else begin
            ff_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                ff_q[i] <= ff_q[i-1];
            end
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/pin_mux_nx1_sync.sv
// N:1 pin mux: synchronised inputs, debounced select, break-before-make
// channel switching and a registered output pin.
module pin_mux_nx1_sync
    import pin_mux_pkg::*;
#(
    parameter int   N_CH        = 4,
    parameter int   SYNC_STAGES = 2,
    parameter int   DEBOUNCE    = 4,
    parameter int   GAP         = 1,
    parameter logic IDLE_VAL    = 1'b0,
    localparam int  SEL_W       = $clog2(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    inout  wire  [N_CH-1:0]  din_pin,
    output logic [N_CH-1:0]  din_dir,
    inout  wire  [SEL_W-1:0] sel_pin,
    output logic [SEL_W-1:0] sel_dir,
    inout  wire              en_pin,
    output logic             en_dir,
    inout  wire              mux_pin,
    output logic             mux_dir,
    output logic [SEL_W-1:0] active_ch,
    output logic             switching,
    output logic             sel_err
);

    localparam logic [7:0] DB_MAX   = 8'(DEBOUNCE);
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    logic [N_CH-1:0]  sync_din;
    logic [SEL_W-1:0] sync_sel;
    logic             sync_en;

    state_e           state_q, state_d;
    logic             out_q, out_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [SEL_W-1:0] target_q, target_d;
    logic [SEL_W-1:0] cand_q, cand_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             err_q, err_d;
    logic             sel_same, sel_valid, sel_stable, sel_in_range;

    pin_sync #(.WIDTH(N_CH),  .STAGES(SYNC_STAGES)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .d_i(din_pin), .q_o(sync_din));
    pin_sync #(.WIDTH(SEL_W), .STAGES(SYNC_STAGES)) u_sync_sel (
        .clk(clk), .rst_n(rst_n), .d_i(sel_pin), .q_o(sync_sel));
    pin_sync #(.WIDTH(1),     .STAGES(SYNC_STAGES)) u_sync_en (
        .clk(clk), .rst_n(rst_n), .d_i(en_pin),  .q_o(sync_en));

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        sel_same  = (sync_sel == cand_q);
        sel_valid = sel_same && (cnt_q == DB_MAX - 8'd1);
        // Stable stays true after the one-shot valid, so a select that settles
        // during BREAK is still acted on once the FSM is back in RUN.
        sel_stable   = sel_same && (cnt_q >= DB_MAX - 8'd1);
        sel_in_range = (int'(cand_q) < N_CH);
        if (!sel_same) begin
            cand_d = sync_sel;
            cnt_d  = '0;
        end else if (cnt_q != DB_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        target_d = target_q;
        gap_d    = gap_q;
        err_d    = err_q;
        out_d    = IDLE_VAL;
        if (sel_valid && !sel_in_range) begin
            err_d = 1'b1;
        end
        case (state_q)
            RUN: begin
                out_d = sync_en ? sync_din[active_q] : IDLE_VAL;
                if (sel_stable && sel_in_range && (cand_q != active_q)) begin
                    if (GAP == 0) begin
                        active_d = cand_q;
                    end else begin
                        state_d  = BREAK;
                        target_d = cand_q;
                        gap_d    = '0;
                        out_d    = IDLE_VAL;
                    end
                end
            end
            BREAK: begin
                if (gap_q == GAP_LAST) begin
                    active_d = target_q;
                    state_d  = RUN;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            out_q    <= IDLE_VAL;
            active_q <= '0;
            target_q <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            active_q <= active_d;
            target_q <= target_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            err_q    <= err_d;
        end
    end

    assign mux_pin   = out_q;
    assign active_ch = active_q;
    assign switching = (state_q == BREAK);
    assign sel_err   = err_q;
    assign din_dir   = {N_CH{PIN_DIR_IN}};
    assign sel_dir   = {SEL_W{PIN_DIR_IN}};
    assign en_dir    = PIN_DIR_IN;
    assign mux_dir   = PIN_DIR_OUT;

endmodule
